// File: rtl/xadac_pkg.sv
// xadac_pkg: shared types and constants for the xadac decode/execute protocol.
//   - vector/ID widths, VRF address width, instruction field offsets
//   - issue FSM state type
//   - request/response payload structs carried by xadac_if
package xadac_pkg;

  localparam int unsigned VecDataWidth  = 64;
  localparam int unsigned VecSumWidth   = 32;
  localparam int unsigned VecElemWidth  = 8;
  localparam int unsigned IdWidth       = 4;
  localparam int unsigned RsDataWidth   = 32;
  localparam int unsigned NumRs         = 2;
  localparam int unsigned NumVs         = 3;
  localparam int unsigned VregAddrWidth = 5;

  localparam int unsigned InstrVdLsb  = 7;
  localparam int unsigned InstrVs1Lsb = 15;
  localparam int unsigned InstrVs2Lsb = 20;

  typedef logic [IdWidth-1:0]       id_t;
  typedef logic [VecDataWidth-1:0]  vec_t;
  typedef logic [VregAddrWidth-1:0] vreg_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEC  = 2'd1,
    ST_EXE  = 2'd2,
    ST_RET  = 2'd3
  } state_e;

  typedef struct packed {
    id_t         id;
    logic [31:0] instr;
  } dec_req_t;

  typedef struct packed {
    id_t  id;
    logic accept;
  } dec_rsp_t;

  typedef struct packed {
    id_t                                    id;
    logic [31:0]                            instr;
    logic [NumRs-1:0][RsDataWidth-1:0]      rs_data;
    logic [NumVs-1:0][VecDataWidth-1:0]     vs_data;
  } exe_req_t;

  typedef struct packed {
    id_t        id;
    vreg_addr_t vd_addr;
    vec_t       vd_data;
    logic       vd_write;
  } exe_rsp_t;

  function automatic vreg_addr_t instr_vd(input logic [31:0] ins);
    return ins[InstrVdLsb +: VregAddrWidth];
  endfunction

  function automatic vreg_addr_t instr_vs1(input logic [31:0] ins);
    return ins[InstrVs1Lsb +: VregAddrWidth];
  endfunction

  function automatic vreg_addr_t instr_vs2(input logic [31:0] ins);
    return ins[InstrVs2Lsb +: VregAddrWidth];
  endfunction

endpackage

// File: rtl/xadac_if.sv
// xadac_if: decode and execute channels between an issuing master and an
// accelerator slave. Each channel is a valid/ready request plus a
// valid/ready response.
//   mst modport: drives requests and response readies
//   slv modport: drives request readies and responses
interface xadac_if;
  import xadac_pkg::*;

  logic     dec_req_valid;
  logic     dec_req_ready;
  dec_req_t dec_req;
  logic     dec_rsp_valid;
  logic     dec_rsp_ready;
  dec_rsp_t dec_rsp;

  logic     exe_req_valid;
  logic     exe_req_ready;
  exe_req_t exe_req;
  logic     exe_rsp_valid;
  logic     exe_rsp_ready;
  exe_rsp_t exe_rsp;

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready,
    output exe_req_valid, exe_req, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp,
    input  exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready,
    input  exe_req_valid, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp,
    output exe_req_ready, exe_rsp_valid, exe_rsp
  );

endinterface

// File: rtl/xadac_vrf.sv
// xadac_vrf: NumVregs x VecDataWidth vector register file.
//   clk          clock
//   i_wr_en/addr/data   single synchronous write port
//   i_rd_addr/o_rd_data combinational host read port
//   i_src_addr/o_src_data three combinational source read ports
// Contents are not reset.
module xadac_vrf
  import xadac_pkg::*;
#(
  parameter int unsigned NumVregs = 32
) (
  input  logic                                clk,
  input  logic                                i_wr_en,
  input  logic [VregAddrWidth-1:0]            i_wr_addr,
  input  logic [VecDataWidth-1:0]             i_wr_data,
  input  logic [VregAddrWidth-1:0]            i_rd_addr,
  output logic [VecDataWidth-1:0]             o_rd_data,
  input  logic [NumVs-1:0][VregAddrWidth-1:0] i_src_addr,
  output logic [NumVs-1:0][VecDataWidth-1:0]  o_src_data
);

  logic [VecDataWidth-1:0] r_mem [NumVregs];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

  always_comb begin
    o_src_data = '0;
    for (int unsigned i = 0; i < NumVs; i++) begin
      o_src_data[i] = r_mem[i_src_addr[i]];
    end
  end

endmodule

// File: rtl/xadac_issue.sv
// xadac_issue: master end of the xadac decode/execute protocol.
// Takes one 32-bit instruction at a time, offers it for decode, and for
// accepted instructions reads vs1/vs2/vd from the local VRF, issues the
// execute request and writes the returned result back.
//   clk, rst                          clock, synchronous active-high reset
//   instr_valid/instr_ready/instr     instruction input handshake
//   done_valid/done_accept/done_err   one-cycle retire pulse and status
//   vrf_wr_*                          host VRF write (honoured in IDLE only)
//   vrf_rd_addr/vrf_rd_data           combinational host VRF read
//   mst                               decode/execute channels to the slave
module xadac_issue
  import xadac_pkg::*;
#(
  parameter int unsigned NumVregs = 32,
  parameter int unsigned IdInit   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [31:0]              instr,
  output logic                     done_valid,
  output logic                     done_accept,
  output logic                     done_err,
  input  logic                     vrf_wr_en,
  input  logic [VregAddrWidth-1:0] vrf_wr_addr,
  input  logic [VecDataWidth-1:0]  vrf_wr_data,
  input  logic [VregAddrWidth-1:0] vrf_rd_addr,
  output logic [VecDataWidth-1:0]  vrf_rd_data,
  xadac_if.mst                     mst
);

  state_e                             r_state;
  id_t                                r_id;
  id_t                                r_cur_id;
  logic [31:0]                        r_instr;
  logic                               r_err;
  logic                               r_accept;
  logic [NumVs-1:0][VecDataWidth-1:0] r_vs;

  logic                               w_take;
  logic                               w_dec_done;
  logic                               w_exe_done;
  logic                               w_exe_wr;
  logic                               w_host_wr;
  logic                               w_vrf_we;
  logic [VregAddrWidth-1:0]           w_vrf_waddr;
  logic [VecDataWidth-1:0]            w_vrf_wdata;
  logic [NumVs-1:0][VregAddrWidth-1:0] w_src_addr;
  logic [NumVs-1:0][VecDataWidth-1:0]  w_src_data;

  // Ready is masked during reset so nothing is taken while rst is held.
  assign instr_ready = (r_state == ST_IDLE) && !rst;
  assign w_take      = instr_ready && instr_valid;
  assign w_dec_done  = (r_state == ST_DEC) && mst.dec_rsp_valid;
  assign w_exe_done  = (r_state == ST_EXE) && mst.exe_rsp_valid;

  // Write-back is suppressed when reset coincides with the execute
  // handshake, so a dropped instruction never lands in the VRF.
  assign w_exe_wr    = w_exe_done && mst.exe_rsp.vd_write && !rst;
  assign w_host_wr   = vrf_wr_en && (r_state == ST_IDLE) && !rst;
  assign w_vrf_we    = w_exe_wr || w_host_wr;
  assign w_vrf_waddr = w_exe_wr ? mst.exe_rsp.vd_addr : vrf_wr_addr;
  assign w_vrf_wdata = w_exe_wr ? mst.exe_rsp.vd_data : vrf_wr_data;

  assign w_src_addr[0] = instr_vs1(r_instr);
  assign w_src_addr[1] = instr_vs2(r_instr);
  assign w_src_addr[2] = instr_vd(r_instr);

  xadac_vrf #(
    .NumVregs(NumVregs)
  ) u_vrf (
    .clk        (clk),
    .i_wr_en    (w_vrf_we),
    .i_wr_addr  (w_vrf_waddr),
    .i_wr_data  (w_vrf_wdata),
    .i_rd_addr  (vrf_rd_addr),
    .o_rd_data  (vrf_rd_data),
    .i_src_addr (w_src_addr),
    .o_src_data (w_src_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_id     <= id_t'(IdInit);
      r_err    <= 1'b0;
      r_accept <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_err   <= 1'b0;
            r_state <= ST_DEC;
          end
        end
        ST_DEC: begin
          if (w_dec_done) begin
            if (mst.dec_rsp.id != r_cur_id) begin
              r_err <= 1'b1;
            end
            r_accept <= mst.dec_rsp.accept;
            r_state  <= mst.dec_rsp.accept ? ST_EXE : ST_RET;
          end
        end
        ST_EXE: begin
          if (w_exe_done) begin
            if (mst.exe_rsp.id != r_cur_id) begin
              r_err <= 1'b1;
            end
            r_accept <= 1'b1;
            r_state  <= ST_RET;
          end
        end
        ST_RET: begin
          r_err   <= 1'b0;
          r_id    <= r_id + id_t'(1);
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Source operands are captured on the decode handshake: the VRF cannot
  // change between then and the execute handshake, and any host write in
  // the accepting IDLE cycle has already landed.
  always_ff @(posedge clk) begin
    if (w_take) begin
      r_instr  <= instr;
      r_cur_id <= r_id;
    end
    if (w_dec_done && mst.dec_rsp.accept) begin
      r_vs <= w_src_data;
    end
  end

  assign mst.dec_req_valid = (r_state == ST_DEC);
  assign mst.dec_rsp_ready = (r_state == ST_DEC);
  assign mst.exe_req_valid = (r_state == ST_EXE);
  assign mst.exe_rsp_ready = (r_state == ST_EXE);

  always_comb begin
    mst.dec_req       = '0;
    mst.dec_req.id    = r_cur_id;
    mst.dec_req.instr = r_instr;
  end

  always_comb begin
    mst.exe_req         = '0;
    mst.exe_req.id      = r_cur_id;
    mst.exe_req.instr   = r_instr;
    mst.exe_req.rs_data = '0;
    mst.exe_req.vs_data = r_vs;
  end

  assign done_valid  = (r_state == ST_RET);
  assign done_accept = done_valid && r_accept;
  assign done_err    = done_valid && r_err;

endmodule

// File: tb/tb_xadac_issue.sv
// tb_xadac_issue: directed bench for xadac_issue with a behavioural vmacc
// slave (signed 8-bit elements, 32-bit lane sums, Jlen from instr[27:25],
// accepts Jlen 1 or 4) driving the slave side of xadac_if.
module tb_xadac_issue;
  import xadac_pkg::*;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        done_valid;
  logic        done_accept;
  logic        done_err;
  logic        vrf_wr_en;
  logic [4:0]  vrf_wr_addr;
  logic [63:0] vrf_wr_data;
  logic [4:0]  vrf_rd_addr;
  logic [63:0] vrf_rd_data;

  xadac_if bus ();

  xadac_issue #(
    .NumVregs (32),
    .IdInit   (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .done_valid  (done_valid),
    .done_accept (done_accept),
    .done_err    (done_err),
    .vrf_wr_en   (vrf_wr_en),
    .vrf_wr_addr (vrf_wr_addr),
    .vrf_wr_data (vrf_wr_data),
    .vrf_rd_addr (vrf_rd_addr),
    .vrf_rd_data (vrf_rd_data),
    .mst         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural vmacc slave ----------------
  logic stall_mode = 1'b0;
  int   stall_cnt  = 0;

  function automatic logic [63:0] vmacc(input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] c, input int unsigned jlen);
    logic [63:0]       r;
    logic signed [7:0] ea;
    logic signed [7:0] eb;
    int                acc;
    int                pa;
    int                pb;
    r = '0;
    for (int unsigned l = 0; l < 2; l++) begin
      acc = int'(c[l*32 +: 32]);
      for (int unsigned j = 0; j < 4 && j < jlen; j++) begin
        ea  = a[(l*jlen + j)*8 +: 8];
        eb  = b[(l*jlen + j)*8 +: 8];
        pa  = ea;
        pb  = eb;
        acc = acc + pa * pb;
      end
      r[l*32 +: 32] = acc;
    end
    return r;
  endfunction

  always_comb begin
    bus.dec_req_ready  = stall_mode ? (bus.dec_req_valid && stall_cnt == 5) : 1'b1;
    bus.dec_rsp_valid  = stall_mode ? (bus.dec_req_valid && stall_cnt == 5) : bus.dec_req_valid;
    bus.dec_rsp        = '0;
    bus.dec_rsp.id     = stall_mode ? (bus.dec_req.id ^ id_t'(1)) : bus.dec_req.id;
    bus.dec_rsp.accept = (bus.dec_req.instr[27:25] == 3'd1) || (bus.dec_req.instr[27:25] == 3'd4);
    bus.exe_req_ready  = 1'b1;
    bus.exe_rsp_valid  = bus.exe_req_valid;
    bus.exe_rsp        = '0;
    bus.exe_rsp.id       = bus.exe_req.id;
    bus.exe_rsp.vd_write = 1'b1;
    bus.exe_rsp.vd_addr  = bus.exe_req.instr[11:7];
    bus.exe_rsp.vd_data  = vmacc(bus.exe_req.vs_data[0], bus.exe_req.vs_data[1],
                                 bus.exe_req.vs_data[2], 32'(bus.exe_req.instr[27:25]));
  end

  always @(posedge clk) begin
    if (bus.dec_req_valid && !bus.dec_rsp_valid) stall_cnt <= stall_cnt + 1;
    else stall_cnt <= 0;
  end

  // ---------------- protocol monitor ----------------
  logic     prev_dec_v = 1'b0;
  dec_req_t prev_dec   = '0;
  int       stab_err   = 0;
  int       rdy_err    = 0;
  int       exe_cnt    = 0;
  id_t      id_q[$];

  always @(negedge clk) begin
    if (bus.dec_req_valid === 1'b1) begin
      if (prev_dec_v && bus.dec_req !== prev_dec) stab_err++;
      if (!prev_dec_v) id_q.push_back(bus.dec_req.id);
    end
    if (instr_ready === 1'b1 && (bus.dec_req_valid || bus.exe_req_valid || done_valid)) rdy_err++;
    if (bus.exe_req_valid === 1'b1) exe_cnt++;
    prev_dec_v = (bus.dec_req_valid === 1'b1);
    prev_dec   = bus.dec_req;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] mk(input logic [2:0] jl, input logic [4:0] vs1,
                                     input logic [4:0] vs2, input logic [4:0] vd);
    return {4'b0, jl, vs2, vs1, 3'b0, vd, 7'h0B};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic vrf_put(input logic [4:0] a, input logic [63:0] d);
    sync();
    vrf_wr_en   = 1'b1;
    vrf_wr_addr = a;
    vrf_wr_data = d;
    @(posedge clk);
    #1;
    vrf_wr_en = 1'b0;
  endtask

  task automatic vrf_chk(input string tag, input logic [4:0] a, input logic [63:0] e);
    sync();
    vrf_rd_addr = a;
    #1;
    chk(tag, vrf_rd_data, e);
  endtask

  // Cycle count includes the accepting IDLE cycle and the RET cycle.
  task automatic run_instr(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                           input logic [63:0] wd, output int cyc, output logic acc,
                           output logic err);
    logic seen;
    seen = 1'b0;
    acc  = 1'b0;
    err  = 1'b0;
    cyc  = 1;
    sync();
    instr       = ins;
    instr_valid = 1'b1;
    vrf_wr_en   = we;
    vrf_wr_addr = wa;
    vrf_wr_data = wd;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      vrf_wr_en   = 1'b0;
      cyc++;
      if (done_valid) begin
        seen = 1'b1;
        acc  = done_accept;
        err  = done_err;
      end
    end
    chk("done_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_b2b(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    logic [31:0] lst [3];
    int unsigned idx;
    int unsigned dones;
    logic        took;
    lst   = '{a, b, c};
    idx   = 0;
    dones = 0;
    sync();
    instr       = lst[0];
    instr_valid = 1'b1;
    for (int k = 0; k < 60 && dones < 3; k++) begin
      took = instr_ready && instr_valid;
      @(posedge clk);
      #1;
      if (took) begin
        idx++;
        if (idx < 3) instr = lst[idx];
        else instr_valid = 1'b0;
      end
      if (done_valid) begin
        dones++;
        chk("b2b_accept", 64'(done_accept), 64'd1);
      end
    end
    instr_valid = 1'b0;
    chk("b2b_dones", 64'(dones), 64'd3);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  int   cyc;
  logic acc;
  logic err;
  int   ex0;

  initial begin
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    vrf_wr_en   = 1'b0;
    vrf_wr_addr = '0;
    vrf_wr_data = '0;
    vrf_rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_ready", 64'(instr_ready), 64'd0);
    chk("rst_dec_valid", 64'(bus.dec_req_valid), 64'd0);
    chk("rst_exe_valid", 64'(bus.exe_req_valid), 64'd0);
    chk("rst_done_valid", 64'(done_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_ready", 64'(instr_ready), 64'd1);

    // Jlen=1
    vrf_put(5'd1, 64'h00000000_000003FF);
    vrf_put(5'd2, 64'h00000000_00000502);
    vrf_put(5'd3, 64'h00000000_00000000);
    run_instr(mk(3'd1, 5'd1, 5'd2, 5'd3), 1'b0, 5'd0, 64'd0, cyc, acc, err);
    chk("j1_latency", 64'(cyc), 64'd4);
    chk("j1_accept", 64'(acc), 64'd1);
    chk("j1_err", 64'(err), 64'd0);
    vrf_chk("j1_vd", 5'd3, 64'h0000000F_FFFFFFFE);

    // Jlen=4, vd written by host in the same cycle the instruction is taken
    vrf_put(5'd1, 64'h01010101_01010101);
    vrf_put(5'd2, 64'h02020202_02020202);
    run_instr(mk(3'd4, 5'd1, 5'd2, 5'd3), 1'b1, 5'd3, 64'h00000010_00000010, cyc, acc, err);
    chk("j4_accept", 64'(acc), 64'd1);
    vrf_chk("j4_vd", 5'd3, 64'h00000018_00000018);

    // Reject
    ex0 = exe_cnt;
    run_instr(mk(3'd2, 5'd1, 5'd2, 5'd3), 1'b0, 5'd0, 64'd0, cyc, acc, err);
    chk("rej_latency", 64'(cyc), 64'd3);
    chk("rej_accept", 64'(acc), 64'd0);
    chk("rej_err", 64'(err), 64'd0);
    chk("rej_no_exe", 64'(exe_cnt), 64'(ex0));
    vrf_chk("rej_vd", 5'd3, 64'h00000018_00000018);

    // Reset while in EXE
    vrf_put(5'd11, 64'h00000000_00001234);
    sync();
    instr       = mk(3'd1, 5'd1, 5'd2, 5'd11);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_in_exe", 64'(bus.exe_req_valid), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstx_dec_valid", 64'(bus.dec_req_valid), 64'd0);
    chk("rstx_exe_valid", 64'(bus.exe_req_valid), 64'd0);
    chk("rstx_done_valid", 64'(done_valid), 64'd0);
    rst = 1'b0;
    #1;
    chk("rstx_idle", 64'(instr_ready), 64'd1);
    vrf_chk("rstx_vd", 5'd11, 64'h00000000_00001234);

    // Back-to-back, IDs restart at 0 after reset
    vrf_put(5'd4, 64'h00000001_00000001);
    vrf_put(5'd5, 64'h7F7F7F7F_80808080);
    vrf_put(5'd6, 64'h01010101_FFFFFFFF);
    vrf_put(5'd7, 64'h00000000_00000000);
    vrf_put(5'd8, 64'h00000000_0000FE05);
    vrf_put(5'd9, 64'h00000000_00000303);
    vrf_put(5'd10, 64'h00000064_00000064);
    id_q.delete();
    run_b2b(mk(3'd1, 5'd1, 5'd2, 5'd4), mk(3'd4, 5'd5, 5'd6, 5'd7), mk(3'd1, 5'd8, 5'd9, 5'd10));
    chk("b2b_id_count", 64'(id_q.size()), 64'd3);
    if (id_q.size() == 3) begin
      chk("b2b_id0", 64'(id_q[0]), 64'd0);
      chk("b2b_id1", 64'(id_q[1]), 64'd1);
      chk("b2b_id2", 64'(id_q[2]), 64'd2);
    end
    vrf_chk("b2b_vd4", 5'd4, 64'h00000003_00000003);
    vrf_chk("b2b_vd7", 5'd7, 64'h000001FC_00000200);
    vrf_chk("b2b_vd10", 5'd10, 64'h0000005E_00000073);

    // Stalling slave: decode response 5 cycles late with a wrong ID
    vrf_put(5'd12, 64'h00000000_00000000);
    stab_err   = 0;
    stall_mode = 1'b1;
    run_instr(mk(3'd1, 5'd1, 5'd2, 5'd12), 1'b0, 5'd0, 64'd0, cyc, acc, err);
    stall_mode = 1'b0;
    chk("stall_latency", 64'(cyc), 64'd9);
    chk("stall_accept", 64'(acc), 64'd1);
    chk("stall_err", 64'(err), 64'd1);
    chk("stall_req_stable", 64'(stab_err), 64'd0);
    vrf_chk("stall_vd", 5'd12, 64'h00000002_00000002);

    // Error flag does not leak into the next instruction
    run_instr(mk(3'd1, 5'd1, 5'd2, 5'd13), 1'b0, 5'd0, 64'd0, cyc, acc, err);
    chk("after_stall_err", 64'(err), 64'd0);

    chk("ready_only_idle", 64'(rdy_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
